// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_packet_arbiter: packet-granular round-robin AXI-Stream arbiter.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module axis_packet_arbiter #(
  parameter int NUM_INPUTS     = 2,
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int MAX_BEATS      = 0,
  localparam int ID_W          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                   clk,
  input  logic                                   sresetn,
  input  logic [NUM_INPUTS*8*AXIS_BYTES-1:0]     axis_i_tdata,
  input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0]   axis_i_tuser,
  input  logic [NUM_INPUTS*AXIS_BYTES-1:0]       axis_i_tkeep,
  input  logic [NUM_INPUTS-1:0]                  axis_i_tlast,
  input  logic [NUM_INPUTS-1:0]                  axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]                  axis_i_drop,
  output logic [NUM_INPUTS-1:0]                  axis_i_tready,
  output logic [8*AXIS_BYTES-1:0]                axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]              axis_o_tuser,
  output logic [AXIS_BYTES-1:0]                  axis_o_tkeep,
  output logic                                   axis_o_tlast,
  output logic                                   axis_o_tvalid,
  input  logic                                   axis_o_tready,
  output logic                                   axis_o_drop,
  output logic [ID_W-1:0]                        axis_o_id,
  output logic                                   overlength
);

  localparam int C_DW = 8 * AXIS_BYTES;
  localparam int C_CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   g_q, g_d;
  logic [ID_W-1:0]   lg_q, lg_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;

  logic [C_DW-1:0]           tdata_a [NUM_INPUTS];
  logic [AXIS_USER_BITS-1:0] tuser_a [NUM_INPUTS];
  logic [AXIS_BYTES-1:0]     tkeep_a [NUM_INPUTS];

  generate
    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_slice
      assign tdata_a[n] = axis_i_tdata[n*C_DW +: C_DW];
      assign tuser_a[n] = axis_i_tuser[n*AXIS_USER_BITS +: AXIS_USER_BITS];
      assign tkeep_a[n] = axis_i_tkeep[n*AXIS_BYTES +: AXIS_BYTES];
    end
  endgenerate

  logic sel_valid, sel_last, sel_drop, ovl;
  logic [ID_W-1:0] pick;

  assign sel_valid    = axis_i_tvalid[g_q];
  assign sel_last     = axis_i_tlast[g_q];
  assign sel_drop     = axis_i_drop[g_q];
  assign axis_o_tdata = tdata_a[g_q];
  assign axis_o_tuser = tuser_a[g_q];
  assign axis_o_tkeep = tkeep_a[g_q];
  assign axis_o_tlast = sel_last;
  assign ovl = (MAX_BEATS != 0) && (cnt_q == C_CNT_LAST) && !sel_last;

  // Requesters above lg outrank those at or below it; the lowest index wins in each group.
  always_comb begin
    pick = g_q;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (axis_i_tvalid[i] && (i <= int'(lg_q))) pick = ID_W'(i);
    end
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (axis_i_tvalid[i] && (i > int'(lg_q))) pick = ID_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    lg_d          = lg_q;
    cnt_d         = cnt_q;
    axis_i_tready = '0;
    axis_o_tvalid = 1'b0;
    axis_o_drop   = 1'b0;
    axis_o_id     = '0;
    overlength    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|axis_i_tvalid) begin
          g_d     = pick;
          cnt_d   = '0;
          state_d = S_PASS;
        end
      end
      S_PASS: begin
        axis_o_tvalid      = sel_valid;
        axis_i_tready[g_q] = axis_o_tready;
        axis_o_drop        = sel_drop | ovl;
        axis_o_id          = g_q;
        if (sel_valid && axis_o_tready) begin
          if (sel_last || sel_drop) begin
            lg_d    = g_q;
            state_d = S_IDLE;
          end else if (ovl) begin
            overlength = 1'b1;
            state_d    = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // Swallow the tail of a truncated packet without presenting it downstream.
        axis_i_tready[g_q] = 1'b1;
        if (sel_valid && sel_last) begin
          lg_d    = g_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      lg_q    <= ID_W'(NUM_INPUTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
`default_nettype none
// tb_axis_packet_arbiter: directed and randomized packet traffic against a
// transaction-level arbitration model, checked every cycle.
module tb_axis_packet_arbiter;

  localparam int N    = 4;
  localparam int NB   = 2;
  localparam int UB   = 2;
  localparam int MAXB = 4;
  localparam int DW   = 8 * NB;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic sresetn;
  logic [N*DW-1:0] i_tdata;
  logic [N*UB-1:0] i_tuser;
  logic [N*NB-1:0] i_tkeep;
  logic [N-1:0]    i_tlast, i_tvalid, i_drop, i_tready;
  logic [DW-1:0]   o_tdata;
  logic [UB-1:0]   o_tuser;
  logic [NB-1:0]   o_tkeep;
  logic            o_tlast, o_tvalid, o_tready, o_drop, ovl_o;
  logic [IW-1:0]   o_id;

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .NUM_INPUTS(N), .AXIS_BYTES(NB), .AXIS_USER_BITS(UB), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tdata(i_tdata), .axis_i_tuser(i_tuser), .axis_i_tkeep(i_tkeep),
    .axis_i_tlast(i_tlast), .axis_i_tvalid(i_tvalid), .axis_i_drop(i_drop),
    .axis_i_tready(i_tready),
    .axis_o_tdata(o_tdata), .axis_o_tuser(o_tuser), .axis_o_tkeep(o_tkeep),
    .axis_o_tlast(o_tlast), .axis_o_tvalid(o_tvalid), .axis_o_tready(o_tready),
    .axis_o_drop(o_drop), .axis_o_id(o_id), .overlength(ovl_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [UB-1:0] user;
    logic [NB-1:0] keep;
    logic          last;
    logic          drop;
  } beat_t;

  beat_t q [N][$];

  // Reference view: who owns the sink, whether the owner's tail is being discarded,
  // how many beats of the owner's packet went out, and who was served last.
  int m_owner;
  int m_last;
  int m_beats;
  bit m_disc;

  int errors = 0;
  int checks = 0;
  int ovl_pulses = 0;
  int drop_beats = 0;
  int out_beats  = 0;
  int grants[$];
  bit dut_in_pkt = 1'b0;
  bit gap_mode = 1'b0;
  bit rdy_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_beats = 0;
    m_disc  = 1'b0;
    dut_in_pkt = 1'b0;
  endtask

  task automatic add_pkt(input int n, input int len, input int drop_at);
    beat_t b;
    for (int i = 1; i <= len; i++) begin
      b.data = DW'($urandom);
      b.user = UB'($urandom);
      b.keep = NB'($urandom);
      b.last = (i == len);
      b.drop = (i == drop_at);
      q[n].push_back(b);
    end
  endtask

  task automatic drive();
    bit on;
    for (int n = 0; n < N; n++) begin
      on = (q[n].size() > 0) && (!gap_mode || ($urandom_range(0, 3) != 0));
      i_tvalid[n] = on;
      if (q[n].size() > 0) begin
        i_tdata[n*DW +: DW] = q[n][0].data;
        i_tuser[n*UB +: UB] = q[n][0].user;
        i_tkeep[n*NB +: NB] = q[n][0].keep;
        i_tlast[n]          = q[n][0].last;
        i_drop[n]           = q[n][0].drop;
      end else begin
        i_tdata[n*DW +: DW] = DW'($urandom);
        i_tuser[n*UB +: UB] = UB'($urandom);
        i_tkeep[n*NB +: NB] = NB'($urandom);
        i_tlast[n]          = 1'($urandom);
        i_drop[n]           = 1'($urandom);
      end
    end
    o_tready = !rdy_mode || ($urandom_range(0, 1) == 1);
  endtask

  task automatic cycle();
    int o;
    bit fire, trunc, found, exp_tv;
    logic [N-1:0] exp_rdy;
    beat_t b;
    drive();
    @(negedge clk);
    exp_rdy = '0;
    if (m_owner < 0) begin
      chk("idle_tvalid", o_tvalid, 0);
      chk("idle_tready", i_tready, 0);
      chk("idle_id", o_id, 0);
      chk("idle_ovl", ovl_o, 0);
      if (i_tvalid != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && i_tvalid[(m_last + k) % N]) begin
            found   = 1'b1;
            m_owner = (m_last + k) % N;
          end
        end
        m_beats = 0;
        m_disc  = 1'b0;
      end
    end else if (!m_disc) begin
      o = m_owner;
      b = q[o][0];
      exp_tv     = i_tvalid[o];
      exp_rdy[o] = o_tready;
      trunc = (m_beats == MAXB - 1) && !b.last;
      chk("pass_tvalid", o_tvalid, exp_tv);
      chk("pass_tready", i_tready, exp_rdy);
      chk("pass_id", o_id, o);
      if (exp_tv) begin
        chk("pass_tdata", o_tdata, b.data);
        chk("pass_tuser", o_tuser, b.user);
        chk("pass_tkeep", o_tkeep, b.keep);
        chk("pass_tlast", o_tlast, b.last);
        chk("pass_drop", o_drop, b.drop | trunc);
      end
      fire = exp_tv && o_tready;
      chk("pass_ovl", ovl_o, fire && trunc && !b.drop);
      if (fire) begin
        void'(q[o].pop_front());
        if (b.last || b.drop) begin
          m_last  = o;
          m_owner = -1;
        end else if (trunc) begin
          m_disc = 1'b1;
        end else begin
          m_beats++;
        end
      end
    end else begin
      o = m_owner;
      exp_rdy[o] = 1'b1;
      chk("flush_tvalid", o_tvalid, 0);
      chk("flush_tready", i_tready, exp_rdy);
      chk("flush_id", o_id, 0);
      chk("flush_ovl", ovl_o, 0);
      if (i_tvalid[o]) begin
        b = q[o].pop_front();
        if (b.last) begin
          m_last  = o;
          m_owner = -1;
          m_disc  = 1'b0;
        end
      end
    end
    if (o_tvalid && o_tready) begin
      out_beats++;
      if (o_drop) drop_beats++;
      if (!dut_in_pkt) grants.push_back(int'(o_id));
      dut_in_pkt = !(o_tlast || o_drop);
    end
    if (ovl_o) ovl_pulses++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit busy();
    bit r;
    r = (m_owner >= 0);
    for (int n = 0; n < N; n++) if (q[n].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain(input int bound);
    int c;
    c = 0;
    while (busy() && c < bound) begin
      cycle();
      c++;
    end
    chk("drain_timeout", busy(), 0);
    repeat (2) cycle();
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_tready"}, i_tready, 0);
    chk({tag, "_tvalid"}, o_tvalid, 0);
    chk({tag, "_drop"}, o_drop, 0);
    chk({tag, "_ovl"}, ovl_o, 0);
  endtask

  task automatic do_reset();
    sresetn = 1'b0;
    #2;
    reset_outputs_check("rst");
    for (int n = 0; n < N; n++) q[n].delete();
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    model_reset();
  endtask

  int ob0, db0, ov0;

  initial begin
    sresetn  = 1'b0;
    i_tdata  = '0; i_tuser = '0; i_tkeep = '0;
    i_tlast  = '0; i_drop  = '0;
    i_tvalid = '1;
    o_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_check("rst_init");
    i_tvalid = '0;
    sresetn  = 1'b1;

    // Inputs 0 and 2 request together: 0 first, one idle cycle, then 2.
    add_pkt(0, 4, 0);
    add_pkt(2, 4, 0);
    grants.delete();
    drain(200);
    chk("t1_npkts", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("t1_grant0", grants[0], 0);
      chk("t1_grant1", grants[1], 2);
    end

    // All inputs continuously requesting: strict rotation from input 0.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int n = 0; n < N; n++) add_pkt(n, 1 + int'($urandom_range(0, 2)), 0);
    grants.delete();
    drain(400);
    chk("t2_npkts", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++) chk("t2_order", grants[i], i % N);

    // Drop on beat 3 of 5 ends the packet; the remaining two beats form a new one.
    grants.delete();
    ob0 = out_beats; db0 = drop_beats; ov0 = ovl_pulses;
    add_pkt(1, 5, 3);
    drain(200);
    chk("t3_beats", out_beats - ob0, 5);
    chk("t3_drops", drop_beats - db0, 1);
    chk("t3_ovl", ovl_pulses - ov0, 0);
    chk("t3_npkts", grants.size(), 2);

    // Overlength: 7 beats with a 4-beat limit.
    ob0 = out_beats; db0 = drop_beats; ov0 = ovl_pulses;
    add_pkt(0, 7, 0);
    drain(200);
    chk("t4_beats", out_beats - ob0, 4);
    chk("t4_drops", drop_beats - db0, 1);
    chk("t4_ovl", ovl_pulses - ov0, 1);

    // Exactly MAX_BEATS beats ending in tlast is legal.
    ob0 = out_beats; db0 = drop_beats; ov0 = ovl_pulses;
    add_pkt(0, 4, 0);
    drain(200);
    chk("t5_beats", out_beats - ob0, 4);
    chk("t5_drops", drop_beats - db0, 0);
    chk("t5_ovl", ovl_pulses - ov0, 0);

    // Random sink backpressure during a 3-beat and a 6-beat packet.
    rdy_mode = 1'b1;
    ob0 = out_beats;
    add_pkt(2, 3, 0);
    drain(300);
    chk("t6_beats", out_beats - ob0, 3);
    add_pkt(2, 6, 0);
    drain(300);
    rdy_mode = 1'b0;

    // Reset mid-packet abandons it and re-arms input 0 priority.
    add_pkt(3, 6, 0);
    repeat (3) cycle();
    do_reset();
    add_pkt(3, 2, 0);
    add_pkt(1, 2, 0);
    grants.delete();
    drain(200);
    chk("t7_npkts", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("t7_grant0", grants[0], 1);
      chk("t7_grant1", grants[1], 3);
    end

    // Random traffic with tvalid gaps, backpressure, drops and overlength.
    gap_mode = 1'b1;
    rdy_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      add_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 7)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
    end
    drain(6000);
    gap_mode = 1'b0;
    rdy_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream packet sink, normally the write side of the packet FIFO, between NUM_INPUTS requesters. A grant is held from the first beat to the tlast or drop beat of a packet, so packets are never interleaved. The per-input drop flag is forwarded to the sink, and packets longer than MAX_BEATS are forced to drop. The block sits directly in front of the FIFO, in the FIFO's input clock domain.

## Interface
- NUM_INPUTS, 2: number of requesters (≥2).
- AXIS_BYTES, 1: tdata bytes per beat.
- AXIS_USER_BITS, 1: tuser width.
- MAX_BEATS, 0: maximum beats per packet; 0 disables the length check.
- clk  in  1  sole clock.
- sresetn  in  1  asynchronous, active-low reset.
- axis_i_tdata  in  NUM_INPUTS*8*AXIS_BYTES  flattened; input n occupies slice n.
- axis_i_tuser  in  NUM_INPUTS*AXIS_USER_BITS  flattened.
- axis_i_tkeep  in  NUM_INPUTS*AXIS_BYTES  flattened.
- axis_i_tlast, axis_i_tvalid, axis_i_drop  in  NUM_INPUTS  per-input bits.
- axis_i_tready  out  NUM_INPUTS  per-input ready.
- axis_o_tdata/tuser/tkeep  out  8*AXIS_BYTES / AXIS_USER_BITS / AXIS_BYTES  granted input's fields.
- axis_o_tlast, axis_o_tvalid  out  1  granted input's tlast/tvalid.
- axis_o_tready  in  1  sink ready.
- axis_o_drop  out  1  discard-current-packet flag, valid with axis_o_tvalid.
- axis_o_id  out  max(1,$clog2(NUM_INPUTS))  index of the granted input.
- overlength  out  1  one-cycle pulse when a packet is truncated.

## Operation
- State registers: state (IDLE, PASS, FLUSH), grant index g, last index lg, beat counter cnt of width $clog2(MAX_BEATS+1).
- IDLE:
  - All tready are 0 and axis_o_tvalid is 0.
  - If any tvalid is high, g is set to the first set tvalid after lg, searching modulo NUM_INPUTS. Then cnt is set to 0 and the state goes to PASS.
- PASS: the datapath is combinational from input g.
  - axis_o_* = input g fields; axis_i_tready[g] = axis_o_tready; all other tready are 0.
  - axis_o_drop = axis_i_drop[g] | ovl, where ovl = (MAX_BEATS≠0) & (cnt==MAX_BEATS-1) & !tlast[g].
  - A beat is transferred when axis_o_tvalid & axis_o_tready.
  - Beat with tlast or drop[g]: lg←g, go to IDLE.
  - Beat with ovl: pulse overlength and go to FLUSH.
  - Any other beat: cnt←cnt+1.
- FLUSH:
  - axis_i_tready[g]=1 and axis_o_tvalid=0, so the remainder of the packet is discarded upstream.
  - On the input beat with tlast: lg←g, go to IDLE.
- A beat carrying both tlast and drop is a normal termination with drop forwarded; it does not enter FLUSH.
- When MAX_BEATS ≠ 0, a beat carrying tlast exactly at cnt==MAX_BEATS-1 is a legal packet: no drop is asserted and no FLUSH follows.
- axis_o_id = g in PASS and 0 otherwise.
- The sink interface is compatible with the packet FIFO: axis_o_drop maps to its drop input.

## Timing
- Reset (asynchronous assert, synchronous release) sets state=IDLE, lg=NUM_INPUTS-1 so input 0 wins first, cnt=0, g=0.
- Outputs during reset: all tready 0, axis_o_tvalid 0, axis_o_drop 0, overlength 0.
- Arbitration costs one cycle. A packet's first beat can transfer at the earliest one cycle after its tvalid is seen in IDLE, and there is exactly one idle cycle between back-to-back packets.
- The data path has zero latency in PASS (combinational tvalid, tready and data).
- A requester is never preempted mid-packet. With all inputs continuously requesting, grants rotate 0,1,…,N-1,0.
- If reset asserts mid-packet, the partial packet is abandoned. The sink must be reset together with the arbiter.
- tvalid deasserting mid-packet on input g simply stalls the arbiter; there is no timeout.

## Test plan
- Reset, then inputs 0 and 2 (N=3) each send a 4-beat packet simultaneously → output carries input 0's 4 beats with id=0, one idle cycle, then input 2's 4 beats with id=2.
- All 4 inputs (N=4) present continuously for 8 packets → grant order is 0,1,2,3,0,1,2,3 and no beats interleave.
- Input 1 sends a 5-beat packet with drop set on beat 3 → three beats are output, the third with axis_o_drop=1, then the state returns to IDLE. Input 1's next beat starts a new packet.
- MAX_BEATS=4, input 0 sends a 7-beat packet → four beats are output, the fourth with drop=1, and overlength pulses once. Beats 5-7 are accepted with axis_o_tvalid=0, then arbitration resumes.
- MAX_BEATS=4, 4-beat packet with tlast on beat 4 → no drop and no overlength.
- axis_o_tready toggled randomly during a 6-beat packet → the output beat sequence is identical and exactly one input tready follows the sink ready.
